watch_alarm_hub: RTL and testbench
==================================

// Module: watch_alarm_hub
// PURPOSE
//  Parametrised timekeeping core for the smartwatch family: 1 Hz prescaler, HH:MM:SS counter and
//  NUM_ALARMS programmable alarms with snooze/dismiss state machine. Drives the seven-segment
//  decoder with time and the alarm indicator with alarm status.
// PARAMETERS
//  CLK_HZ        50_000_000  input clock frequency; one tick every CLK_HZ cycles
//  NUM_ALARMS    4           number of alarm slots (>=1)
//  RING_SECONDS  60          ticks an alarm rings before auto-dismiss
//  SNOOZE_MIN    5           snooze length in minutes (SNOOZE_MIN*60 ticks)
// PORTS
//  clk            in   1           system clock, rising edge
//  reset          in   1           asynchronous, active-low reset
//  load_time      in   1           1-cycle strobe: load set_sec/min/hour
//  set_sec        in   6           seconds to load (0..59)
//  set_min        in   6           minutes to load (0..59)
//  set_hour       in   5           hours to load (0..23)
//  alarm_wr       in   1           1-cycle strobe: write one alarm slot
//  alarm_idx      in   IW          slot index, IW=max(1,$clog2(NUM_ALARMS))
//  alarm_min      in   6           alarm minute
//  alarm_hour     in   5           alarm hour
//  alarm_on       in   1           slot enable written with slot
//  snooze         in   1           1-cycle strobe
//  dismiss        in   1           1-cycle strobe
//  seconds        out  6           current seconds
//  minutes        out  6           current minutes
//  hours          out  5           current hours (24 h)
//  tick_1hz       out  1           1-cycle pulse per second
//  load_err       out  1           1-cycle pulse: load or alarm write rejected (out of range)
//  ringing        out  1           high in RINGING
//  alarm_id       out  IW          slot currently ringing/snoozed
//  pending        out  NUM_ALARMS  slots matched but not yet serviced
// BEHAVIOUR
//  Reset: all outputs 0, time 00:00:00, all alarm slots disabled 00:00, FSM IDLE, prescaler 0.
//  Prescaler counts 0..CLK_HZ-1; tick_1hz asserted in the cycle the count wraps.
//  On tick: sec+1; 59->0 carries to min; min 59->0 carries to hour; 23:59:59 -> 00:00:00.
//  load_time: if all fields in range, time updates next cycle, prescaler cleared, tick suppressed
//   that cycle; otherwise time unchanged, load_err=1. load_time beats a same-cycle tick.
//  alarm_wr: range-checked as load; valid write updates slot next cycle; invalid -> load_err.
//  Match: on a tick producing sec==0 with min/hour equal to an enabled slot -> set pending bit.
//   A loaded time does not trigger a match.
//  FSM IDLE: any pending -> RINGING, alarm_id = lowest pending index, ring counter = RING_SECONDS.
//  RINGING: ring counter decrements per tick; reaching 0 -> clear pending[alarm_id], IDLE.
//   dismiss -> clear pending[alarm_id], IDLE. snooze -> SNOOZED, snooze counter = SNOOZE_MIN*60.
//   dismiss and snooze same cycle: dismiss wins.
//  SNOOZED: counter decrements per tick; 0 -> RINGING (same alarm_id, ring counter reloaded).
//   dismiss -> clear pending[alarm_id], IDLE. snooze ignored.
//  Slot disabled by alarm_wr while ringing/snoozed -> clear its pending bit, IDLE.
//  Other slots matching during RINGING/SNOOZED only set pending; serviced after return to IDLE.
//  Reset mid-ring: immediate IDLE, pending cleared.
// CONFIGURATION
//  WATCH_12H_EN defined: extra outputs hour12 (4 bit, 1..12) and pm (1 bit), combinational from
//   hours (0->12 AM, 12->12 PM, 13->1 PM). Undefined: ports and logic absent, 24 h only.
// STRUCTURE
//  watch_pkg: state enum (IDLE, RINGING, SNOOZED), constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23,
//   widths SEC_W=6, MIN_W=6, HOUR_W=5.
//  Sub-module tick_prescaler (CLK_HZ; clk, reset, clear, tick) instantiated once.
// TESTING (CLK_HZ=4, NUM_ALARMS=4, RING_SECONDS=3, SNOOZE_MIN=1)
//  Wrap: load 23:59:58, 8 cycles -> 00:00:00, tick_1hz every 4th cycle.
//  Bad load: set_min=60 -> load_err 1 cycle, time unchanged.
//  Ring/timeout: slot 2 on at 07:30, load 07:29:59 -> ringing, alarm_id=2 after tick; off after 3 ticks.
//  Snooze: snooze during ring -> ringing=0 for 60 ticks, then ringing=1, alarm_id=2; dismiss -> IDLE.
//  Priority: slots 1 and 3 both 06:00 -> alarm_id=1; dismiss -> alarm_id=3 next cycle.
//  Simultaneous snooze+dismiss -> IDLE, pending[alarm_id]=0; reset mid-ring -> all outputs 0.

Source files
------------

// File: rtl/watch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : watch_pkg                                                      |
// | Purpose : Shared types, field widths and range limits for the watch      |
// |           timekeeping core (watch_alarm_hub, tick_prescaler).            |
// | Contents: state_e  - alarm service FSM states (IDLE, RINGING, SNOOZED)   |
// |           SEC_W/MIN_W/HOUR_W - time field widths                         |
// |           SEC_MAX/MIN_MAX/HOUR_MAX - largest legal field values          |
// |           hm_valid() - minute/hour range check shared by load and alarm  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package watch_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } state_e;

  // Minute/hour legality; used both for time loads and alarm slot writes.
  function automatic logic hm_valid(input logic [MIN_W-1:0]  m,
                                    input logic [HOUR_W-1:0] h);
    return (m <= MIN_MAX) && (h <= HOUR_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tick_prescaler                                                 |
// | Purpose : Divides the system clock down to a one-cycle 1 Hz tick. The    |
// |           counter runs 0..CLK_HZ-1 and the tick is asserted in the cycle |
// |           the count wraps.                                               |
// | Ports   : clk   in  system clock, rising edge                            |
// |           reset in  asynchronous active-low reset                        |
// |           clear in  restart the second (counter to 0, tick suppressed)   |
// |           tick  out one-cycle pulse per CLK_HZ cycles                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tick_prescaler #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CW-1:0] cnt_q;
  logic          wrap;

  assign wrap = (cnt_q == CW'(CLK_HZ - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear || wrap) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // A clear restarts the second, so the wrap that would coincide with it is
  // not reported as a tick.
  assign tick = wrap && !clear;

endmodule
`default_nettype wire

// File: rtl/watch_alarm_hub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : watch_alarm_hub                                                |
// | Purpose : Timekeeping core: 1 Hz prescaler, HH:MM:SS counter and         |
// |           NUM_ALARMS programmable alarm slots with a snooze/dismiss FSM. |
// | Ports   : clk, reset (async active-low)                                  |
// |           load_time/set_sec/set_min/set_hour - time load strobe + value  |
// |           alarm_wr/alarm_idx/alarm_min/alarm_hour/alarm_on - slot write  |
// |           snooze, dismiss        - user strobes                          |
// |           seconds/minutes/hours  - current time (24 h)                   |
// |           tick_1hz               - 1 Hz pulse                            |
// |           load_err               - rejected load/alarm write pulse       |
// |           ringing/alarm_id       - alarm service status                  |
// |           pending                - matched, not yet serviced slots       |
// | Config  : WATCH_12H_EN adds hour12 (1..12) and pm outputs.               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module watch_alarm_hub
  import watch_pkg::*;
#(
  parameter  int CLK_HZ       = 50_000_000,
  parameter  int NUM_ALARMS   = 4,
  parameter  int RING_SECONDS = 60,
  parameter  int SNOOZE_MIN   = 5,
  localparam int IW           = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_time,
  input  logic [SEC_W-1:0]      set_sec,
  input  logic [MIN_W-1:0]      set_min,
  input  logic [HOUR_W-1:0]     set_hour,
  input  logic                  alarm_wr,
  input  logic [IW-1:0]         alarm_idx,
  input  logic [MIN_W-1:0]      alarm_min,
  input  logic [HOUR_W-1:0]     alarm_hour,
  input  logic                  alarm_on,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [SEC_W-1:0]      seconds,
  output logic [MIN_W-1:0]      minutes,
  output logic [HOUR_W-1:0]     hours,
  output logic                  tick_1hz,
  output logic                  load_err,
  output logic                  ringing,
  output logic [IW-1:0]         alarm_id,
  output logic [NUM_ALARMS-1:0] pending
`ifdef WATCH_12H_EN
  ,
  output logic [3:0]            hour12,
  output logic                  pm
`endif
);

  localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
  localparam int CNT_MAX      = (RING_SECONDS > SNOOZE_TICKS) ? RING_SECONDS : SNOOZE_TICKS;
  localparam int CNT_W        = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  // ---------------------------------------------------------------- state
  logic [SEC_W-1:0]      sec_q, sec_d;
  logic [MIN_W-1:0]      min_q, min_d;
  logic [HOUR_W-1:0]     hour_q, hour_d;
  logic                  load_err_q, load_err_d;

  logic [MIN_W-1:0]      al_min_q  [NUM_ALARMS];
  logic [HOUR_W-1:0]     al_hour_q [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] al_en_q;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IW-1:0]         alarm_id_q;
  logic                  ringing_q;
  logic [NUM_ALARMS-1:0] pending_q;

  // ---------------------------------------------------------------- wires
  logic                  tick;
  logic                  load_ok, load_apply;
  logic                  wr_ok, wr_apply;
  logic                  sec_wrap;
  logic [NUM_ALARMS-1:0] match_set;
  logic [NUM_ALARMS-1:0] dis_mask;
  logic [NUM_ALARMS-1:0] cur_mask;
  logic [NUM_ALARMS-1:0] pend_eff;
  logic [IW-1:0]         lowest_idx;
  logic                  cur_disabled;
  logic                  count_done;

  // Request validation. A slot index beyond NUM_ALARMS-1 (possible when
  // NUM_ALARMS is not a power of two) is rejected like an out-of-range time.
  assign load_ok    = (set_sec <= SEC_MAX) && hm_valid(set_min, set_hour);
  assign load_apply = load_time && load_ok;
  assign wr_ok      = ({1'b0, alarm_idx} < (IW+1)'(NUM_ALARMS))
                      && hm_valid(alarm_min, alarm_hour);
  assign wr_apply   = alarm_wr && wr_ok;
  assign load_err_d = (load_time && !load_ok) || (alarm_wr && !wr_ok);

  // A valid load restarts the second; that also suppresses the tick, which
  // is how a load wins over a coincident tick.
  tick_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (load_apply),
    .tick  (tick)
  );

  // ------------------------------------------------------ time next-state
  always_comb begin
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    sec_wrap = 1'b0;
    if (load_apply) begin
      sec_d  = set_sec;
      min_d  = set_min;
      hour_d = set_hour;
    end else if (tick) begin
      if (sec_q >= SEC_MAX) begin
        sec_d    = '0;
        sec_wrap = 1'b1;
        if (min_q >= MIN_MAX) begin
          min_d  = '0;
          hour_d = (hour_q >= HOUR_MAX) ? '0 : hour_q + HOUR_W'(1);
        end else begin
          min_d = min_q + MIN_W'(1);
        end
      end else begin
        sec_d = sec_q + SEC_W'(1);
      end
    end
  end

  // Alarms fire only on a counted minute boundary; sec_wrap is never set by
  // a load, so loading a matching time does not ring.
  always_comb begin
    match_set = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (sec_wrap && al_en_q[i] && (al_min_q[i] == min_d) && (al_hour_q[i] == hour_d)) begin
        match_set[i] = 1'b1;
      end
    end
  end

  // Writing a slot disabled withdraws any pending request from it.
  assign dis_mask     = (wr_apply && !alarm_on) ? (NUM_ALARMS'(1) << alarm_idx) : '0;
  assign cur_mask     = NUM_ALARMS'(1) << alarm_id_q;
  assign pend_eff     = pending_q & ~dis_mask;
  assign cur_disabled = |(dis_mask & cur_mask);
  assign count_done   = tick && (cnt_q <= CNT_W'(1));

  // Lowest-index pending slot is serviced first.
  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (pend_eff[i]) begin
        lowest_idx = IW'(i);
      end
    end
  end

  // ------------------------------------------------- time and alarm slots
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      load_err_q <= 1'b0;
      al_en_q    <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        al_min_q[i]  <= '0;
        al_hour_q[i] <= '0;
      end
    end else begin
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      load_err_q <= load_err_d;
      if (wr_apply) begin
        al_min_q[alarm_idx]  <= alarm_min;
        al_hour_q[alarm_idx] <= alarm_hour;
        al_en_q[alarm_idx]   <= alarm_on;
      end
    end
  end

  // ------------------------------------------------ alarm service FSM
  // cnt_q is shared: ring countdown in RINGING, snooze countdown in SNOOZED.
  // The default pending update merges new matches and slot disables; the
  // branches that finish servicing also drop the current slot's bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      alarm_id_q <= '0;
      ringing_q  <= 1'b0;
      pending_q  <= '0;
    end else begin
      pending_q <= pend_eff | match_set;
      case (state_q)
        ST_IDLE: begin
          if (|pend_eff) begin
            state_q    <= ST_RINGING;
            alarm_id_q <= lowest_idx;
            cnt_q      <= CNT_W'(RING_SECONDS);
            ringing_q  <= 1'b1;
          end
        end
        ST_RINGING: begin
          if (dismiss || cur_disabled || count_done) begin
            pending_q <= (pend_eff & ~cur_mask) | match_set;
            state_q   <= ST_IDLE;
            ringing_q <= 1'b0;
          end else if (snooze) begin
            state_q   <= ST_SNOOZED;
            cnt_q     <= CNT_W'(SNOOZE_TICKS);
            ringing_q <= 1'b0;
          end else if (tick) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_SNOOZED: begin
          if (dismiss || cur_disabled) begin
            pending_q <= (pend_eff & ~cur_mask) | match_set;
            state_q   <= ST_IDLE;
            ringing_q <= 1'b0;
          end else if (count_done) begin
            state_q   <= ST_RINGING;
            cnt_q     <= CNT_W'(RING_SECONDS);
            ringing_q <= 1'b1;
          end else if (tick) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          ringing_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------- outputs
  assign seconds  = sec_q;
  assign minutes  = min_q;
  assign hours    = hour_q;
  assign tick_1hz = tick;
  assign load_err = load_err_q;
  assign ringing  = ringing_q;
  assign alarm_id = alarm_id_q;
  assign pending  = pending_q;

`ifdef WATCH_12H_EN
  // 0 -> 12 AM, 1..11 AM, 12 -> 12 PM, 13..23 -> 1..11 PM.
  always_comb begin
    pm = (hour_q >= 5'd12);
    if (hour_q == '0) begin
      hour12 = 4'd12;
    end else if (hour_q > 5'd12) begin
      hour12 = 4'(hour_q - 5'd12);
    end else begin
      hour12 = 4'(hour_q);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_watch_alarm_hub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_watch_alarm_hub                                             |
// | Purpose : Self-checking bench for watch_alarm_hub with CLK_HZ=4,         |
// |           NUM_ALARMS=4, RING_SECONDS=3, SNOOZE_MIN=1.                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_watch_alarm_hub;

  localparam int NA = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_time = 1'b0;
  logic [5:0]    set_sec = '0;
  logic [5:0]    set_min = '0;
  logic [4:0]    set_hour = '0;
  logic          alarm_wr = 1'b0;
  logic [IW-1:0] alarm_idx = '0;
  logic [5:0]    alarm_min = '0;
  logic [4:0]    alarm_hour = '0;
  logic          alarm_on = 1'b0;
  logic          snooze = 1'b0;
  logic          dismiss = 1'b0;
  logic [5:0]    seconds;
  logic [5:0]    minutes;
  logic [4:0]    hours;
  logic          tick_1hz;
  logic          load_err;
  logic          ringing;
  logic [IW-1:0] alarm_id;
  logic [NA-1:0] pending;

  int checks = 0;
  int errors = 0;

  watch_alarm_hub #(
    .CLK_HZ       (4),
    .NUM_ALARMS   (NA),
    .RING_SECONDS (3),
    .SNOOZE_MIN   (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_time  (load_time),
    .set_sec    (set_sec),
    .set_min    (set_min),
    .set_hour   (set_hour),
    .alarm_wr   (alarm_wr),
    .alarm_idx  (alarm_idx),
    .alarm_min  (alarm_min),
    .alarm_hour (alarm_hour),
    .alarm_on   (alarm_on),
    .snooze     (snooze),
    .dismiss    (dismiss),
    .seconds    (seconds),
    .minutes    (minutes),
    .hours      (hours),
    .tick_1hz   (tick_1hz),
    .load_err   (load_err),
    .ringing    (ringing),
    .alarm_id   (alarm_id),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    logic       exp_err;
    logic [5:0] es;
    logic [5:0] em;
    logic [4:0] eh;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h);
    set_sec   = s;
    set_min   = m;
    set_hour  = h;
    load_time = 1'b1;
    step();
    load_time = 1'b0;
  endtask

  task automatic do_alarm(input logic [IW-1:0] idx, input logic [5:0] m,
                          input logic [4:0] h, input logic on);
    alarm_idx  = idx;
    alarm_min  = m;
    alarm_hour = h;
    alarm_on   = on;
    alarm_wr   = 1'b1;
    step();
    alarm_wr   = 1'b0;
  endtask

  task automatic wait_ring(input logic val, input int budget, input string name);
    int n;
    n = 0;
    while (ringing !== val && n < budget) begin
      step();
      n++;
    end
    if (ringing !== val) begin
      checks++;
      errors++;
      $display("FAIL %s: ringing timeout, got %b required %b", name, ringing, val);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    int n;

    //            s   m   h   err es  em  eh
    vecs[0] = '{6'd56, 6'd34, 5'd12, 1'b0, 6'd56, 6'd34, 5'd12};
    vecs[1] = '{6'd5,  6'd60, 5'd10, 1'b1, 6'd56, 6'd34, 5'd12};
    vecs[2] = '{6'd59, 6'd59, 5'd23, 1'b0, 6'd59, 6'd59, 5'd23};
    vecs[3] = '{6'd60, 6'd10, 5'd10, 1'b1, 6'd59, 6'd59, 5'd23};
    vecs[4] = '{6'd10, 6'd10, 5'd24, 1'b1, 6'd59, 6'd59, 5'd23};
    vecs[5] = '{6'd0,  6'd0,  5'd0,  1'b0, 6'd0,  6'd0,  5'd0};
    vecs[6] = '{6'd59, 6'd29, 5'd7,  1'b0, 6'd59, 6'd29, 5'd7};
    vecs[7] = '{6'd58, 6'd59, 5'd23, 1'b0, 6'd58, 6'd59, 5'd23};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_time", {15'd0, hours, minutes, seconds}, 32'd0);
    chk("reset_flags", {28'd0, tick_1hz, load_err, ringing, 1'b0}, 32'd0);
    chk("reset_alarm_id", {30'd0, alarm_id}, 32'd0);
    chk("reset_pending", {28'd0, pending}, 32'd0);
    reset = 1'b1;

    // Table-driven time loads, valid and out of range
    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].s, vecs[i].m, vecs[i].h);
      chk($sformatf("load%0d_err", i), {31'd0, load_err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("load%0d_time", i), {15'd0, hours, minutes, seconds},
          {15'd0, vecs[i].eh, vecs[i].em, vecs[i].es});
      chk($sformatf("load%0d_tick", i), {31'd0, tick_1hz}, 32'd0);
    end

    // Midnight wrap from 23:59:58, tick every 4th cycle
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("wrap_tick%0d", k), {31'd0, tick_1hz}, {31'd0, (k % 4 == 3)});
      if (k == 4) chk("wrap_2359_59", {15'd0, hours, minutes, seconds}, {15'd0, 5'd23, 6'd59, 6'd59});
    end
    chk("wrap_midnight", {15'd0, hours, minutes, seconds}, 32'd0);

    // Alarm write range check
    do_alarm(2'd2, 6'd30, 5'd24, 1'b1);
    chk("alarm_bad_err", {31'd0, load_err}, 32'd1);
    do_alarm(2'd2, 6'd30, 5'd7, 1'b1);
    chk("alarm_good_err", {31'd0, load_err}, 32'd0);

    // Ring and auto-dismiss after 3 ticks
    do_load(6'd59, 6'd29, 5'd7);
    chk("ring_no_match_on_load", {28'd0, pending}, 32'd0);
    wait_ring(1'b1, 20, "ring_start");
    chk("ring_id", {30'd0, alarm_id}, 32'd2);
    chk("ring_pending", {28'd0, pending}, 32'h4);
    t = 0;
    n = 0;
    while (ringing === 1'b1 && n < 60) begin
      if (tick_1hz) t++;
      step();
      n++;
    end
    chk("ring_ticks", t, 32'd3);
    chk("ring_timeout_off", {31'd0, ringing}, 32'd0);
    chk("ring_timeout_pending", {28'd0, pending}, 32'd0);

    // Snooze for 60 ticks, ring again, then dismiss
    do_load(6'd59, 6'd29, 5'd7);
    wait_ring(1'b1, 20, "snz_ring");
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("snz_off", {31'd0, ringing}, 32'd0);
    chk("snz_pending_kept", {28'd0, pending}, 32'h4);
    t = 0;
    n = 0;
    while (ringing !== 1'b1 && n < 300) begin
      if (tick_1hz) t++;
      step();
      n++;
    end
    chk("snz_ticks", t, 32'd60);
    chk("snz_reringing", {31'd0, ringing}, 32'd1);
    chk("snz_id", {30'd0, alarm_id}, 32'd2);
    dismiss = 1'b1;
    step();
    dismiss = 1'b0;
    chk("snz_dismiss_off", {31'd0, ringing}, 32'd0);
    chk("snz_dismiss_pending", {28'd0, pending}, 32'd0);

    // Two slots matching together: lowest first
    do_alarm(2'd1, 6'd0, 5'd6, 1'b1);
    do_alarm(2'd3, 6'd0, 5'd6, 1'b1);
    do_load(6'd59, 6'd59, 5'd5);
    wait_ring(1'b1, 20, "prio_ring");
    chk("prio_id1", {30'd0, alarm_id}, 32'd1);
    chk("prio_pending", {28'd0, pending}, 32'hA);
    dismiss = 1'b1;
    step();
    dismiss = 1'b0;
    chk("prio_dismiss_pending", {28'd0, pending}, 32'h8);
    wait_ring(1'b1, 3, "prio_ring3");
    chk("prio_id3", {30'd0, alarm_id}, 32'd3);

    // Snooze and dismiss together: dismiss wins
    snooze  = 1'b1;
    dismiss = 1'b1;
    step();
    snooze  = 1'b0;
    dismiss = 1'b0;
    chk("both_off", {31'd0, ringing}, 32'd0);
    chk("both_pending", {28'd0, pending}, 32'd0);
    repeat (6) step();
    chk("both_stays_idle", {31'd0, ringing}, 32'd0);

    // Disabling the ringing slot stops it
    do_alarm(2'd0, 6'd0, 5'd1, 1'b1);
    do_load(6'd59, 6'd59, 5'd0);
    wait_ring(1'b1, 20, "dis_ring");
    chk("dis_id", {30'd0, alarm_id}, 32'd0);
    do_alarm(2'd0, 6'd0, 5'd1, 1'b0);
    chk("dis_off", {31'd0, ringing}, 32'd0);
    chk("dis_pending", {28'd0, pending}, 32'd0);

    // Asynchronous reset while ringing
    do_load(6'd59, 6'd59, 5'd5);
    wait_ring(1'b1, 20, "rst_ring");
    #2;
    reset = 1'b0;
    #1;
    chk("rst_time", {15'd0, hours, minutes, seconds}, 32'd0);
    chk("rst_flags", {29'd0, tick_1hz, load_err, ringing}, 32'd0);
    chk("rst_id_pending", {26'd0, alarm_id, pending}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    // Slots were cleared by reset, so 06:00 no longer rings
    do_load(6'd59, 6'd59, 5'd5);
    repeat (12) step();
    chk("rst_slots_cleared", {27'd0, ringing, pending}, 32'd0);
    chk("rst_time_runs", {15'd0, hours, minutes, seconds}, {15'd0, 5'd6, 6'd0, 6'd2});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
